instruction_fetch_responder: RTL and testbench
==============================================

Name: instruction_fetch_responder

Overview:
Services the fetch stage's instruction request interface: accepts instruction_addr/instruction_fetch_activate and answers with instruction_data/instruction_fetch_done. It sits between the pipeline fetch stage and the instruction memory bus. It issues one valid/ready memory read per miss and holds the last returned word in a one-entry hold register. The answer stays asserted for as long as the fetch stage keeps requesting the same address, so a stalled fetch stage never causes refetching.

Parameters:
ADDR_WIDTH, 32, byte address width of instruction and memory addresses
DATA_WIDTH, 32, instruction/memory word width; addresses must be DATA_WIDTH/8-aligned

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
instruction_addr  input  ADDR_WIDTH  requested fetch address from fetch stage
instruction_fetch_activate  input  1  fetch stage requests instruction_addr
instruction_data  output  DATA_WIDTH  instruction word for instruction_addr
instruction_fetch_done  output  1  instruction_data/instruction_fetch_fault valid for current instruction_addr
instruction_fetch_fault  output  1  fetch faulted (misaligned or bus error); qualified by done
invalidate  input  1  discard hold register and any in-flight response (fence.i)
mem_req_valid  output  1  memory read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_WIDTH  memory read address
mem_resp_valid  input  1  memory response valid (one per accepted request)
mem_resp_data  input  DATA_WIDTH  response word
mem_resp_error  input  1  response is a bus error

Behaviour:
- Reset (rst_n low, takes effect immediately regardless of clk): state IDLE; entry_valid=0; entry_addr=0; entry_data=0; entry_fault=0; stale=0; mem_req_valid=0; mem_req_addr=0; instruction_fetch_done=0; instruction_data=0; instruction_fetch_fault=0.
- Hold register holds entry_valid, entry_addr, entry_data, entry_fault.
- hit = activate && entry_valid && (instruction_addr == entry_addr) && !invalidate.
- instruction_fetch_done = hit, combinational.
- instruction_data = entry_data and instruction_fetch_fault = entry_fault, always driven from registers.
- invalidate clears entry_valid at the next edge.
- FSM states: IDLE, REQ, WAIT. Only one request is ever outstanding.
- IDLE, activate && !hit && !invalidate:
  - If misaligned (low log2(DATA_WIDTH/8) address bits nonzero): fill entry {addr, data 0, fault 1} at the edge; no memory request; done next cycle.
  - Otherwise: latch req_addr=instruction_addr, clear stale, go to REQ.
- REQ:
  - mem_req_valid=1; mem_req_addr=req_addr, stable until accepted.
  - A request is never withdrawn.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: if !stale && !invalidate && activate && instruction_addr==req_addr, fill entry {req_addr, mem_resp_data, mem_resp_error}; otherwise discard the response.
  - Go to IDLE in either case.
- Stale tracking: in REQ or WAIT, stale is set at the edge whenever !activate, instruction_addr != req_addr, or invalidate. stale is sticky until the next IDLE->REQ.
- After a discarded response, IDLE re-evaluates the current request on the next cycle, so a new miss is issued 1 cycle after the discard.
- mem_resp_valid outside WAIT is a protocol violation: ignored, state unchanged.
- Best-case miss latency: activate at cycle 0 -> mem_req_valid cycle 1 (ready=1) -> response cycle 2 -> done cycle 3.
- A hit asserts done in the same cycle.
- Fill overwrites the entry unconditionally.
- A new address that misses leaves the old entry intact until the fill; done is low meanwhile because the address differs.
- Reset mid-REQ/WAIT: request abandoned. Any late response arrives in IDLE and is ignored. The memory side is reset from the same rst_n.

Test Plan:
- Reset; activate=1, addr=0x100; ready=1; resp_valid cycle 2 with data 0xDEADBEEF -> mem_req_valid/addr=0x100 in cycle 1 only; done=1, data=0xDEADBEEF, fault=0 from cycle 3; held 5 more cycles with no further requests.
- Same request, mem_req_ready low cycles 1-4 -> mem_req_valid=1 and mem_req_addr=0x100 stable cycles 1-5; done=0 until the cycle after the response.
- Request 0x100 accepted; addr changes to 0x104 before response (0x11111111) -> 0x100 response discarded; done never high; next request addr=0x104 one cycle after discard; done with the 0x104 data afterwards.
- addr=0x102, activate=1 -> no mem_req_valid ever; done=1, fault=1, data=0 in cycle 1.
- Response with mem_resp_error=1 for 0x200 -> done=1, fault=1 held while requesting 0x200; a subsequent request to 0x204 issues a fresh memory request.
- Hit on 0x100, pulse invalidate -> done=0 that cycle, refetch of 0x100 issued. Separately, drop rst_n in WAIT -> all outputs 0 immediately; a late resp_valid after reset release produces no done.

Source files
------------

// File: rtl/instruction_fetch_responder_if.sv
// Fetch-stage and instruction-memory bundles used by instruction_fetch_responder.
// In each bundle the requester is the master and the answering side is the slave.
interface instr_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] instruction_addr;
   logic                  instruction_fetch_activate;
   logic [DATA_WIDTH-1:0] instruction_data;
   logic                  instruction_fetch_done;
   logic                  instruction_fetch_fault;
   logic                  invalidate;

   modport master (
      output instruction_addr, instruction_fetch_activate, invalidate,
      input  instruction_data, instruction_fetch_done, instruction_fetch_fault
   );

   modport slave (
      input  instruction_addr, instruction_fetch_activate, invalidate,
      output instruction_data, instruction_fetch_done, instruction_fetch_fault
   );
endinterface

interface instr_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_resp_data;
   logic                  mem_resp_error;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
   );
endinterface

// File: rtl/instruction_fetch_responder.sv
// Answers fetch-stage requests from a one-entry hold register, issuing a single
// valid/ready memory read per miss and discarding responses that went stale.
module instruction_fetch_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   instr_fetch_if.slave fetch,
   instr_mem_if.master  mem
);

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t                state_q, state_d;
   logic                  entry_valid_q, entry_valid_d;
   logic [ADDR_WIDTH-1:0] entry_addr_q, entry_addr_d;
   logic [DATA_WIDTH-1:0] entry_data_q, entry_data_d;
   logic                  entry_fault_q, entry_fault_d;
   logic                  stale_q, stale_d;
   logic                  mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;

   logic hit;
   logic misaligned;
   logic req_match;

   assign hit        = fetch.instruction_fetch_activate && entry_valid_q &&
                       (fetch.instruction_addr == entry_addr_q) && !fetch.invalidate;
   assign misaligned = |(fetch.instruction_addr & ALIGN_MASK);
   assign req_match  = fetch.instruction_fetch_activate && (fetch.instruction_addr == req_addr_q);

   assign fetch.instruction_fetch_done  = hit;
   assign fetch.instruction_data        = entry_data_q;
   assign fetch.instruction_fetch_fault = entry_fault_q;
   assign mem.mem_req_valid             = mem_req_valid_q;
   assign mem.mem_req_addr              = req_addr_q;

   always_comb begin
      state_d         = state_q;
      entry_valid_d   = entry_valid_q;
      entry_addr_d    = entry_addr_q;
      entry_data_d    = entry_data_q;
      entry_fault_d   = entry_fault_q;
      stale_d         = stale_q;
      mem_req_valid_d = mem_req_valid_q;
      req_addr_d      = req_addr_q;

      if (fetch.invalidate) begin
         entry_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            // Misaligned fetches fault locally and never reach the memory bus.
            if (fetch.instruction_fetch_activate && !hit && !fetch.invalidate) begin
               if (misaligned) begin
                  entry_valid_d = 1'b1;
                  entry_addr_d  = fetch.instruction_addr;
                  entry_data_d  = '0;
                  entry_fault_d = 1'b1;
               end else begin
                  req_addr_d      = fetch.instruction_addr;
                  mem_req_valid_d = 1'b1;
                  stale_d         = 1'b0;
                  state_d         = REQ;
               end
            end
         end

         REQ: begin
            if (!req_match || fetch.invalidate) begin
               stale_d = 1'b1;
            end
            if (mem.mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               state_d         = WAIT;
            end
         end

         WAIT: begin
            if (!req_match || fetch.invalidate) begin
               stale_d = 1'b1;
            end
            // A response is only kept if the fetch stage still wants exactly this word.
            if (mem.mem_resp_valid) begin
               if (!stale_q && !fetch.invalidate && req_match) begin
                  entry_valid_d = 1'b1;
                  entry_addr_d  = req_addr_q;
                  entry_data_d  = mem.mem_resp_data;
                  entry_fault_d = mem.mem_resp_error;
               end
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         entry_valid_q   <= 1'b0;
         entry_addr_q    <= '0;
         entry_data_q    <= '0;
         entry_fault_q   <= 1'b0;
         stale_q         <= 1'b0;
         mem_req_valid_q <= 1'b0;
         req_addr_q      <= '0;
      end else begin
         state_q         <= state_d;
         entry_valid_q   <= entry_valid_d;
         entry_addr_q    <= entry_addr_d;
         entry_data_q    <= entry_data_d;
         entry_fault_q   <= entry_fault_d;
         stale_q         <= stale_d;
         mem_req_valid_q <= mem_req_valid_d;
         req_addr_q      <= req_addr_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed self-checking bench for instruction_fetch_responder; each task drives
// one scenario cycle by cycle and compares outputs against hand-computed values.
module tb_instruction_fetch_responder;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   instr_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fetch_bus ();
   instr_mem_if   #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

   instruction_fetch_responder #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fetch (fetch_bus),
      .mem   (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      fetch_bus.instruction_addr           = '0;
      fetch_bus.instruction_fetch_activate = 1'b0;
      fetch_bus.invalidate                 = 1'b0;
      mem_bus.mem_req_ready                = 1'b0;
      mem_bus.mem_resp_valid               = 1'b0;
      mem_bus.mem_resp_data                = '0;
      mem_bus.mem_resp_error               = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #3;
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", fetch_bus.instruction_data); end
      checks++; if (fetch_bus.instruction_fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fetch_bus.instruction_fetch_fault); end
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", mem_bus.mem_req_valid); end
      checks++; if (mem_bus.mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_req_addr: got %h expected 00000000", mem_bus.mem_req_addr); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Fills 0x100 with 0xDEADBEEF using best-case latency; leaves the bench in cycle 3.
   task automatic test_basic_miss();
      step();
      fetch_bus.instruction_fetch_activate = 1'b1;
      fetch_bus.instruction_addr           = 32'h100;
      mem_bus.mem_req_ready                = 1'b1;
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_c0_req_valid: got %b expected 0", mem_bus.mem_req_valid); end
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_c0_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_c1_req_valid: got %b expected 1", mem_bus.mem_req_valid); end
      checks++; if (mem_bus.mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL basic_c1_req_addr: got %h expected 00000100", mem_bus.mem_req_addr); end
      step();
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = 32'hDEADBEEF;
      mem_bus.mem_resp_error = 1'b0;
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_c2_req_valid: got %b expected 0", mem_bus.mem_req_valid); end
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_c2_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      mem_bus.mem_resp_valid = 1'b0;
      mem_bus.mem_resp_data  = '0;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_c3_done: got %b expected 1", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_c3_data: got %h expected deadbeef", fetch_bus.instruction_data); end
      checks++; if (fetch_bus.instruction_fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL basic_c3_fault: got %b expected 0", fetch_bus.instruction_fetch_fault); end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         checks++; if (fetch_bus.instruction_fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL hold_done[%0d]: got %b expected 1", c, fetch_bus.instruction_fetch_done); end
         checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_valid[%0d]: got %b expected 0", c, mem_bus.mem_req_valid); end
      end
   endtask

   task automatic test_ready_stall();
      do_reset();
      step();
      fetch_bus.instruction_fetch_activate = 1'b1;
      fetch_bus.instruction_addr           = 32'h100;
      mem_bus.mem_req_ready                = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         step();
         mem_bus.mem_req_ready = (c == 5);
         @(negedge clk);
         checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_req_valid[c%0d]: got %b expected 1", c, mem_bus.mem_req_valid); end
         checks++; if (mem_bus.mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL stall_req_addr[c%0d]: got %h expected 00000100", c, mem_bus.mem_req_addr); end
         checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL stall_done[c%0d]: got %b expected 0", c, fetch_bus.instruction_fetch_done); end
      end
      step();
      mem_bus.mem_req_ready  = 1'b0;
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = 32'hCAFEF00D;
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_c6_req_valid: got %b expected 0", mem_bus.mem_req_valid); end
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL stall_c6_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      mem_bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL stall_c7_done: got %b expected 1", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL stall_c7_data: got %h expected cafef00d", fetch_bus.instruction_data); end
   endtask

   task automatic test_addr_change();
      do_reset();
      step();
      fetch_bus.instruction_fetch_activate = 1'b1;
      fetch_bus.instruction_addr           = 32'h100;
      mem_bus.mem_req_ready                = 1'b1;
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL chg_c1_req_addr: got %h expected 00000100", mem_bus.mem_req_addr); end
      step();
      fetch_bus.instruction_addr = 32'h104;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL chg_c2_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = 32'h11111111;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL chg_c3_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      mem_bus.mem_resp_valid = 1'b0;
      mem_bus.mem_resp_data  = '0;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL chg_c4_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_data !== 32'h0) begin errors++; $display("[TB] FAIL chg_c4_data_discarded: got %h expected 00000000", fetch_bus.instruction_data); end
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL chg_c4_req_valid: got %b expected 0", mem_bus.mem_req_valid); end
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL chg_c5_req_valid: got %b expected 1", mem_bus.mem_req_valid); end
      checks++; if (mem_bus.mem_req_addr !== 32'h104) begin errors++; $display("[TB] FAIL chg_c5_req_addr: got %h expected 00000104", mem_bus.mem_req_addr); end
      step();
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = 32'h22222222;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL chg_c6_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      mem_bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL chg_c7_done: got %b expected 1", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_data !== 32'h22222222) begin errors++; $display("[TB] FAIL chg_c7_data: got %h expected 22222222", fetch_bus.instruction_data); end
   endtask

   task automatic test_misaligned();
      do_reset();
      step();
      fetch_bus.instruction_fetch_activate = 1'b1;
      fetch_bus.instruction_addr           = 32'h102;
      mem_bus.mem_req_ready                = 1'b1;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL mis_c0_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      for (int c = 1; c <= 3; c++) begin
         step();
         @(negedge clk);
         checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_req_valid[c%0d]: got %b expected 0", c, mem_bus.mem_req_valid); end
         checks++; if (fetch_bus.instruction_fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL mis_done[c%0d]: got %b expected 1", c, fetch_bus.instruction_fetch_done); end
         checks++; if (fetch_bus.instruction_fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL mis_fault[c%0d]: got %b expected 1", c, fetch_bus.instruction_fetch_fault); end
         checks++; if (fetch_bus.instruction_data !== 32'h0) begin errors++; $display("[TB] FAIL mis_data[c%0d]: got %h expected 00000000", c, fetch_bus.instruction_data); end
      end
   endtask

   task automatic test_bus_error();
      do_reset();
      step();
      fetch_bus.instruction_fetch_activate = 1'b1;
      fetch_bus.instruction_addr           = 32'h200;
      mem_bus.mem_req_ready                = 1'b1;
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_addr !== 32'h200) begin errors++; $display("[TB] FAIL err_c1_req_addr: got %h expected 00000200", mem_bus.mem_req_addr); end
      step();
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = 32'h00000BAD;
      mem_bus.mem_resp_error = 1'b1;
      for (int c = 3; c <= 4; c++) begin
         step();
         mem_bus.mem_resp_valid = 1'b0;
         mem_bus.mem_resp_error = 1'b0;
         @(negedge clk);
         checks++; if (fetch_bus.instruction_fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL err_done[c%0d]: got %b expected 1", c, fetch_bus.instruction_fetch_done); end
         checks++; if (fetch_bus.instruction_fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL err_fault[c%0d]: got %b expected 1", c, fetch_bus.instruction_fetch_fault); end
         checks++; if (fetch_bus.instruction_data !== 32'h00000BAD) begin errors++; $display("[TB] FAIL err_data[c%0d]: got %h expected 00000bad", c, fetch_bus.instruction_data); end
         checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_req_valid[c%0d]: got %b expected 0", c, mem_bus.mem_req_valid); end
      end
      step();
      fetch_bus.instruction_addr = 32'h204;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL err_c5_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL err_c6_req_valid: got %b expected 1", mem_bus.mem_req_valid); end
      checks++; if (mem_bus.mem_req_addr !== 32'h204) begin errors++; $display("[TB] FAIL err_c6_req_addr: got %h expected 00000204", mem_bus.mem_req_addr); end
   endtask

   task automatic test_invalidate();
      do_reset();
      test_basic_miss();
      step();
      fetch_bus.invalidate = 1'b1;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL inv_pulse_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL inv_pulse_req_valid: got %b expected 0", mem_bus.mem_req_valid); end
      step();
      fetch_bus.invalidate = 1'b0;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL inv_after_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL inv_refetch_valid: got %b expected 1", mem_bus.mem_req_valid); end
      checks++; if (mem_bus.mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL inv_refetch_addr: got %h expected 00000100", mem_bus.mem_req_addr); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      test_basic_miss();
      step();
      fetch_bus.instruction_addr = 32'h104;
      step();
      @(negedge clk);
      checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstw_req_valid: got %b expected 1", mem_bus.mem_req_valid); end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (fetch_bus.instruction_data !== 32'h0) begin errors++; $display("[TB] FAIL rstw_data: got %h expected 00000000", fetch_bus.instruction_data); end
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL rstw_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL rstw_fault: got %b expected 0", fetch_bus.instruction_fetch_fault); end
      checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstw_req_valid_low: got %b expected 0", mem_bus.mem_req_valid); end
      checks++; if (mem_bus.mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstw_req_addr: got %h expected 00000000", mem_bus.mem_req_addr); end
      fetch_bus.instruction_fetch_activate = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = 32'h44444444;
      step();
      mem_bus.mem_resp_valid = 1'b0;
      fetch_bus.instruction_fetch_activate = 1'b1;
      @(negedge clk);
      checks++; if (fetch_bus.instruction_fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL rstw_late_done: got %b expected 0", fetch_bus.instruction_fetch_done); end
      checks++; if (fetch_bus.instruction_data !== 32'h0) begin errors++; $display("[TB] FAIL rstw_late_data: got %h expected 00000000", fetch_bus.instruction_data); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_miss();
      test_hold();
      test_ready_stall();
      test_addr_change();
      test_misaligned();
      test_bus_error();
      test_invalidate();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
